// File: rtl/backbone_pkg.sv
// Shared types and elaboration helpers for the backbone conv engines.
// Feature macro consumed by users of this package: CONV_GEMM_RELU_EN.
package backbone_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 32;

  typedef logic signed [DW_DEF-1:0] data_t;
  typedef logic signed [AW_DEF-1:0] acc_t;

  typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} conv_state_e;

  function automatic int conv_out_dim(int in_dim, int k, int stride, int pad);
    return (in_dim + 2 * pad - k) / stride + 1;
  endfunction

  // Index width that stays legal (>=1 bit) for single-entry dimensions.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_tap_counter.sv
// Walks the ci/kh/kw tap space (kw innermost) and maps each tap to an input
// coordinate; out-of-range coordinates are flagged and their indices forced to 0.
module conv_tap_counter
  import backbone_pkg::*;
#(
  parameter  int CIN    = 1,
  parameter  int H_IN   = 8,
  parameter  int W_IN   = 8,
  parameter  int KH     = 3,
  parameter  int KW     = 3,
  parameter  int STRIDE = 1,
  parameter  int PAD    = 1,
  parameter  int OHW    = 3,
  parameter  int OWW    = 3,
  localparam int CW     = idx_w(CIN),
  localparam int KHW    = idx_w(KH),
  localparam int KWW    = idx_w(KW),
  localparam int HW     = idx_w(H_IN),
  localparam int WW     = idx_w(W_IN)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [OHW-1:0] oh,
  input  logic [OWW-1:0] ow,
  output logic [CW-1:0]  ci,
  output logic [KHW-1:0] kh,
  output logic [KWW-1:0] kw,
  output logic [HW-1:0]  ih,
  output logic [WW-1:0]  iw,
  output logic           in_range,
  output logic           first_tap,
  output logic           last_tap
);

  localparam logic [CW-1:0]  CI_LAST = CW'(CIN - 1);
  localparam logic [KHW-1:0] KH_LAST = KHW'(KH - 1);
  localparam logic [KWW-1:0] KW_LAST = KWW'(KW - 1);

  int   ih_s, iw_s;
  logic ih_ok, iw_ok;

  // Counters sit at tap 0 whenever the engine is not accumulating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ci <= '0;
      kh <= '0;
      kw <= '0;
    end else if (!en) begin
      ci <= '0;
      kh <= '0;
      kw <= '0;
    end else if (kw == KW_LAST) begin
      kw <= '0;
      if (kh == KH_LAST) begin
        kh <= '0;
        ci <= (ci == CI_LAST) ? '0 : ci + 1'b1;
      end else begin
        kh <= kh + 1'b1;
      end
    end else begin
      kw <= kw + 1'b1;
    end
  end

  assign ih_s  = int'(oh) * STRIDE + int'(kh) - PAD;
  assign iw_s  = int'(ow) * STRIDE + int'(kw) - PAD;
  assign ih_ok = (ih_s >= 0) && (ih_s < H_IN);
  assign iw_ok = (iw_s >= 0) && (iw_s < W_IN);

  assign ih        = ih_ok ? HW'(ih_s) : '0;
  assign iw        = iw_ok ? WW'(iw_s) : '0;
  assign in_range  = ih_ok && iw_ok;
  assign first_tap = (ci == '0) && (kh == '0) && (kw == '0);
  assign last_tap  = (ci == CI_LAST) && (kh == KH_LAST) && (kw == KW_LAST);

endmodule

// File: rtl/conv_gemm_engine.sv
// Direct convolution, one output pixel per pass with COUT parallel MAC lanes, raster-order valid/ready output.
// Define CONV_GEMM_RELU_EN to clamp negative results to zero at emit time.
module conv_gemm_engine
  import backbone_pkg::*;
#(
  parameter  int CIN    = 1,
  parameter  int H_IN   = 8,
  parameter  int W_IN   = 8,
  parameter  int COUT   = 4,
  parameter  int KH     = 3,
  parameter  int KW     = 3,
  parameter  int STRIDE = 1,
  parameter  int PAD    = 1,
  parameter  int DW     = 16,
  parameter  int AW     = 32,
  localparam int H_OUT  = conv_out_dim(H_IN, KH, STRIDE, PAD),
  localparam int W_OUT  = conv_out_dim(W_IN, KW, STRIDE, PAD),
  localparam int OHW    = idx_w(H_OUT),
  localparam int OWW    = idx_w(W_OUT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic signed [DW-1:0] fmap_i   [CIN][H_IN][W_IN],
  input  logic signed [DW-1:0] weight_i [COUT][CIN][KH][KW],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_data [COUT],
  output logic [OHW-1:0]       out_oh,
  output logic [OWW-1:0]       out_ow,
  output logic                 out_last
);

  localparam logic [OHW-1:0] OH_LAST = OHW'(H_OUT - 1);
  localparam logic [OWW-1:0] OW_LAST = OWW'(W_OUT - 1);

  conv_state_e state, state_nxt;

  logic [OHW-1:0]            oh;
  logic [OWW-1:0]            ow;
  logic [idx_w(CIN)-1:0]     ci;
  logic [idx_w(KH)-1:0]      kh;
  logic [idx_w(KW)-1:0]      kw;
  logic [idx_w(H_IN)-1:0]    ih;
  logic [idx_w(W_IN)-1:0]    iw;
  logic                      in_range, first_tap, last_tap;
  logic                      pix_last, handshake;
  logic signed [DW-1:0]      fmap_val;
  logic signed [2*DW-1:0]    prod     [COUT];
  logic signed [AW-1:0]      prod_ext [COUT];
  logic signed [AW-1:0]      acc      [COUT];

  conv_tap_counter #(
    .CIN(CIN), .H_IN(H_IN), .W_IN(W_IN), .KH(KH), .KW(KW),
    .STRIDE(STRIDE), .PAD(PAD), .OHW(OHW), .OWW(OWW)
  ) u_taps (
    .clk(clk), .rst_n(rst_n), .en(state == MAC), .oh(oh), .ow(ow),
    .ci(ci), .kh(kh), .kw(kw), .ih(ih), .iw(iw),
    .in_range(in_range), .first_tap(first_tap), .last_tap(last_tap)
  );

  assign pix_last  = (oh == OH_LAST) && (ow == OW_LAST);
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = MAC;
      MAC: begin
        busy = 1'b1;
        if (last_tap) state_nxt = EMIT;
      end
      EMIT: begin
        busy = 1'b1;
        if (handshake) state_nxt = pix_last ? DONE : MAC;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Padding taps feed a zero operand rather than reading the fmap.
  assign fmap_val = in_range ? fmap_i[ci][ih][iw] : '0;

  for (genvar c = 0; c < COUT; c++) begin : g_lane
    assign prod[c]     = fmap_val * weight_i[c][ci][kh][kw];
    assign prod_ext[c] = AW'(prod[c]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oh        <= '0;
      ow        <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_oh    <= '0;
      out_ow    <= '0;
      for (int c = 0; c < COUT; c++) begin
        acc[c]      <= '0;
        out_data[c] <= '0;
      end
    end else begin
      if (state == IDLE && start) begin
        oh <= '0;
        ow <= '0;
      end
      if (state == MAC) begin
        for (int c = 0; c < COUT; c++)
          acc[c] <= first_tap ? prod_ext[c] : acc[c] + prod_ext[c];
      end
      // First EMIT cycle captures the pixel; later cycles wait for the sink.
      if (state == EMIT) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_oh    <= oh;
          out_ow    <= ow;
          out_last  <= pix_last;
          for (int c = 0; c < COUT; c++) begin
`ifdef CONV_GEMM_RELU_EN
            out_data[c] <= acc[c][AW-1] ? '0 : acc[c];
`else
            out_data[c] <= acc[c];
`endif
          end
        end else if (out_ready) begin
          out_valid <= 1'b0;
          if (ow == OW_LAST) begin
            ow <= '0;
            oh <= (oh == OH_LAST) ? '0 : oh + 1'b1;
          end else begin
            ow <= ow + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_gemm_engine.sv
// Randomised bench for conv_gemm_engine: default instance plus a STRIDE=2/PAD=0 instance
// sharing one fmap/weight set, checked against an arithmetic convolution model.
module tb_conv_gemm_engine;

  localparam int NTAP = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] fm [1][8][8];
  logic signed [15:0] wt [4][1][3][3];

  logic start1 = 1'b0, start2 = 1'b0, rdy1 = 1'b1, rdy2 = 1'b1;
  logic busy1, busy2, done1, done2, v1, v2, last1, last2;
  logic signed [31:0] d1 [4];
  logic signed [31:0] d2 [4];
  logic [2:0] oh1, ow1;
  logic [1:0] oh2, ow2;

  conv_gemm_engine u_dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .fmap_i(fm), .weight_i(wt), .out_valid(v1), .out_ready(rdy1),
    .out_data(d1), .out_oh(oh1), .out_ow(ow1), .out_last(last1)
  );

  conv_gemm_engine #(.STRIDE(2), .PAD(0)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .fmap_i(fm), .weight_i(wt), .out_valid(v2), .out_ready(rdy2),
    .out_data(d2), .out_oh(oh2), .out_ow(ow2), .out_last(last2)
  );

  int n_chk = 0;
  int n_fail = 0;
  int sel = 0;

  logic m_v, m_last, m_busy, m_done;
  int m_oh, m_ow;
  logic signed [31:0] m_d [4];

  always_comb begin
    m_v    = sel ? v2 : v1;
    m_last = sel ? last2 : last1;
    m_busy = sel ? busy2 : busy1;
    m_done = sel ? done2 : done1;
    m_oh   = sel ? int'(oh2) : int'(oh1);
    m_ow   = sel ? int'(ow2) : int'(ow1);
    for (int c = 0; c < 4; c++) m_d[c] = sel ? d2[c] : d1[c];
  end

  task automatic set_start(input bit b);
    start1 = (sel == 0) && b;
    start2 = (sel == 1) && b;
  endtask

  task automatic set_ready(input bit b);
    rdy1 = (sel == 0) ? b : 1'b1;
    rdy2 = (sel == 1) ? b : 1'b1;
  endtask

  // Plain sum over the kernel window, skipping taps outside the image, reduced mod 2^32.
  function automatic logic [31:0] model(input int oh, input int ow, input int c, input int st, input int pd);
    longint s;
    logic [63:0] sv;
    logic [31:0] r;
    int ih, iw;
    s = 0;
    for (int kh = 0; kh < 3; kh++)
      for (int kw = 0; kw < 3; kw++) begin
        ih = oh * st + kh - pd;
        iw = ow * st + kw - pd;
        if (ih >= 0 && ih < 8 && iw >= 0 && iw < 8)
          s += longint'(fm[0][ih][iw]) * longint'(wt[c][0][kh][kw]);
      end
    sv = s;
    r = sv[31:0];
`ifdef CONV_GEMM_RELU_EN
    if (r[31]) r = '0;
`endif
    return r;
  endfunction

  task automatic fill_random(input bit small_w);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) fm[0][i][j] = 16'($urandom);
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          wt[c][0][i][j] = small_w ? 16'($signed($urandom_range(0, 15)) - 8) : 16'($urandom);
  endtask

  // mode 0: always ready; 1: random ready plus a start while busy; 2: five stall cycles on pixel (0,3).
  // kind 1: every result must be 0x4000_0000; kind 2: result must equal the fmap at (oh,ow).
  task automatic run_frame(input int s, input int mode, input int kind, input string name);
    int ho, st, pd, eoh, eow, hs, cyc, stall, lasts, first_v, bad;
    bit fin, r;
    logic [31:0] e;
    logic signed [31:0] fe;
    ho = s ? 3 : 8; st = s ? 2 : 1; pd = s ? 0 : 1;
    eoh = 0; eow = 0; hs = 0; cyc = 0; stall = 0; lasts = 0; first_v = 0; fin = 0;
    sel = s;
    @(negedge clk);
    set_ready(1'b1);
    set_start(1'b1);
    while (!fin && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      set_start(mode == 1 && cyc == 20);
      if (cyc == 1) begin
        n_chk++;
        if (m_busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start got %b want 1", name, m_busy); end
      end
      if (m_v && first_v == 0) begin
        first_v = cyc;
        n_chk++;
        if (cyc != NTAP + 2) begin n_fail++; $display("FAIL %s first_latency got %0d want %0d", name, cyc, NTAP + 2); end
      end
      case (mode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 3) != 0);
        default: r = !(m_v && m_oh == 0 && m_ow == 3 && stall < 5);
      endcase
      set_ready(r);
      if (m_v) begin
        n_chk++;
        if (m_oh != eoh || m_ow != eow || m_last !== (eoh == ho - 1 && eow == ho - 1)) begin
          n_fail++;
          $display("FAIL %s index got (%0d,%0d) last=%b want (%0d,%0d)", name, m_oh, m_ow, m_last, eoh, eow);
        end
        for (int c = 0; c < 4; c++) begin
          e = model(eoh, eow, c, st, pd);
          n_chk++;
          if (m_d[c] !== e) begin n_fail++; $display("FAIL %s data(%0d,%0d)[%0d] got %h want %h", name, eoh, eow, c, m_d[c], e); end
          if (kind == 1) begin
            n_chk++;
            if (m_d[c] !== 32'h4000_0000) begin n_fail++; $display("FAIL %s wrap[%0d] got %h want 40000000", name, c, m_d[c]); end
          end
          if (kind == 2) begin
            fe = fm[0][eoh][eow];
            n_chk++;
            if (m_d[c] !== fe) begin n_fail++; $display("FAIL %s identity[%0d] got %h want %h", name, c, m_d[c], fe); end
          end
        end
        if (r) begin
          hs++;
          if (m_last) lasts++;
          if (eow == ho - 1) begin eow = 0; eoh++; end else eow++;
        end else if (mode == 2) begin
          stall++;
        end
      end
      if (m_done) begin
        fin = 1'b1;
        n_chk++;
        if (hs != ho * ho || lasts != 1) begin
          n_fail++;
          $display("FAIL %s handshakes got %0d lasts %0d want %0d lasts 1", name, hs, lasts, ho * ho);
        end
      end
    end
    if (!fin) begin
      n_fail++;
      $display("FAIL %s timeout got no done want done within 5000 cycles", name);
    end
    if (mode == 2) begin
      n_chk++;
      if (stall != 5) begin n_fail++; $display("FAIL %s stall_cycles got %0d want 5", name, stall); end
    end
    // start raised in the done cycle must not launch a new run
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    bad = 0;
    for (int i = 0; i < NTAP + 4; i++) begin
      if (m_v !== 1'b0 || m_busy !== 1'b0) bad++;
      @(negedge clk);
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL %s start_in_done got %0d active cycles want 0", name, bad); end
    set_ready(1'b1);
  endtask

  task automatic check_zero_state(input string name);
    n_chk++;
    if (v1 !== 0 || busy1 !== 0 || done1 !== 0 || last1 !== 0 || oh1 !== 0 || ow1 !== 0 ||
        d1[0] !== 0 || d1[1] !== 0 || d1[2] !== 0 || d1[3] !== 0) begin
      n_fail++;
      $display("FAIL %s dut got v=%b busy=%b done=%b last=%b oh=%0d ow=%0d d0=%h want all zero",
               name, v1, busy1, done1, last1, oh1, ow1, d1[0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_state("reset");
    n_chk++;
    if (v2 !== 0 || busy2 !== 0 || done2 !== 0 || d2[0] !== 0) begin
      n_fail++;
      $display("FAIL reset_s2 got v=%b busy=%b done=%b d0=%h want zero", v2, busy2, done2, d2[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random_conv();
    fill_random(1'b0);
    run_frame(0, 1, 0, "random_full");
    fill_random(1'b1);
    run_frame(0, 1, 0, "random_small");
  endtask

  task automatic test_identity();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) fm[0][i][j] = 16'($urandom_range(0, 32767));
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) wt[c][0][i][j] = (i == 1 && j == 1) ? 16'sd1 : 16'sd0;
    run_frame(0, 0, 2, "identity");
  endtask

  task automatic test_stride2();
    fill_random(1'b0);
    run_frame(1, 1, 0, "stride2");
  endtask

  task automatic test_backpressure();
    fill_random(1'b1);
    run_frame(0, 2, 0, "backpressure");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) fm[0][i][j] = -16'sd32768;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) wt[c][0][i][j] = -16'sd32768;
    run_frame(1, 0, 1, "wrap_pad0");
    run_frame(0, 1, 0, "wrap_pad1");
  endtask

  task automatic test_reset_midrun();
    int hs, cyc, bad;
    fill_random(1'b0);
    sel = 0;
    set_ready(1'b1);
    @(negedge clk);
    set_start(1'b1);
    hs = 0; cyc = 0;
    while (hs < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      set_start(1'b0);
      if (v1 && rdy1) hs++;
    end
    n_chk++;
    if (hs != 2) begin n_fail++; $display("FAIL midrun_progress got %0d handshakes want 2", hs); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_state("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (done1 !== 1'b0 || v1 !== 1'b0) bad++;
      @(negedge clk);
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL midrun_no_done got %0d active cycles want 0", bad); end
    run_frame(0, 1, 0, "after_midrun_reset");
  endtask

  task automatic test_back_to_back();
    fill_random(1'b0);
    run_frame(0, 0, 0, "b2b_first");
    fill_random(1'b0);
    run_frame(0, 0, 0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_random_conv();
    test_identity();
    test_stride2();
    test_backpressure();
    test_wrap();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
